// File: rtl/ahbl_pkg.sv
// Shared AHB-Lite encodings, data-phase state and byte-lane helpers.
// Imported by the SRAM controller and its write buffer.
package ahbl_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WR,
    ST_ERR1,
    ST_ERR2
  } dp_state_t;

  function automatic logic [7:0] strb_gen(
    input logic [2:0] size,
    input logic [2:0] a
  );
    logic [7:0] s;
    unique case (size)
      HSIZE_BYTE:  s = 8'h01 << a;
      HSIZE_HALF:  s = 8'h03 << {a[2:1], 1'b0};
      HSIZE_WORD:  s = 8'h0F << {a[2], 2'b00};
      HSIZE_DWORD: s = 8'hFF;
      default:     s = 8'h00;
    endcase
    return s;
  endfunction

  // Oversized transfers count as misaligned.
  function automatic logic size_err(
    input logic [2:0] size,
    input logic [2:0] a
  );
    logic e;
    unique case (size)
      HSIZE_BYTE:  e = 1'b0;
      HSIZE_HALF:  e = a[0];
      HSIZE_WORD:  e = |a[1:0];
      HSIZE_DWORD: e = |a;
      default:     e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/ahbl_wbuf.sv
// One-entry posted write buffer with per-byte read forwarding.
// Ports: load/drain controls, load payload, read address, SRAM data in, entry and forwarded data out.
module ahbl_wbuf
  import ahbl_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          drain,
  input  logic [AW-1:0] ld_addr,
  input  logic [7:0]    ld_strb,
  input  logic [63:0]   ld_data,
  input  logic [AW-1:0] rd_addr,
  input  logic [63:0]   sram_rdata,
  output logic          valid,
  output logic [AW-1:0] addr,
  output logic [7:0]    strb,
  output logic [63:0]   data,
  output logic [63:0]   rdata
);

  logic hit;

  // A load in a drain cycle replaces the entry being written out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      addr  <= '0;
      strb  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      addr  <= ld_addr;
      strb  <= ld_strb;
      data  <= ld_data;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

  assign hit = valid && (addr == rd_addr);

  always_comb begin
    rdata = sram_rdata;
    for (int k = 0; k < 8; k++) begin
      if (hit && strb[k]) begin
        rdata[8*k +: 8] = data[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/ahbl_sram64_ctrl.sv
// AHB-Lite slave for a 1024x64 single-port sync SRAM; zero-wait reads, posted writes.
// Ports: AHB-Lite slave (H*) and SRAM macro pins (SRAM*), single clock, async active-low reset.
module ahbl_sram64_ctrl
  import ahbl_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic [63:0]   HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [63:0]   HRDATA,
  input  logic [63:0]   SRAMRDATA,
  output logic [AW-1:0] SRAMADDR,
  output logic [7:0]    SRAMWEN,
  output logic [63:0]   SRAMWDATA,
  output logic          SRAMCS0
);

  dp_state_t     state;
  dp_state_t     state_nxt;
  logic          acc;
  logic          bad;
  logic          rd_acc;
  logic          wr_acc;
  logic          err_acc;
  logic          rd_req;
  logic          conflict;
  logic [AW-1:0] ap_addr;
  logic [AW-1:0] dp_addr;
  logic [7:0]    dp_strb;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [7:0]    wb_strb;
  logic [63:0]   wb_data;
  logic [63:0]   fwd_data;
  logic          wb_load;
  logic          wb_drain;
  logic          unused_ok;

  assign ap_addr = HADDR[AW+2:3];
  assign acc     = HSEL && HREADY &&
                   (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
  assign bad     = size_err(HSIZE, HADDR[2:0]);
  assign rd_acc  = acc && !bad && !HWRITE;
  assign wr_acc  = acc && !bad && HWRITE;
  assign err_acc = acc && bad;

  // HREADY is left out so the stall does not feed back on itself.
  assign rd_req   = HSEL && HTRANS[1] && !HWRITE;
  assign conflict = (state == ST_WR) && wb_valid && rd_req;

  assign unused_ok = ^{HADDR[31:AW+3]};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == ST_ERR1) begin
      state_nxt = ST_ERR2;
    end else if (HREADY) begin
      unique case (1'b1)
        rd_acc:  state_nxt = ST_RD;
        wr_acc:  state_nxt = ST_WR;
        err_acc: state_nxt = ST_ERR1;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_addr <= '0;
      dp_strb <= '0;
    end else if (acc) begin
      dp_addr <= ap_addr;
      dp_strb <= strb_gen(HSIZE, HADDR[2:0]);
    end
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    unique case (state)
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
      end
      ST_ERR2: HRESP = HRESP_ERROR;
      ST_WR:   HREADYOUT = !conflict;
      default: ;
    endcase
  end

  assign wb_load  = (state == ST_WR) && HREADYOUT;
  assign wb_drain = wb_valid && !rd_acc;

  ahbl_wbuf #(
    .AW(AW)
  ) u_wbuf (
    .clk        (HCLK),
    .rst_n      (HRESETn),
    .load       (wb_load),
    .drain      (wb_drain),
    .ld_addr    (dp_addr),
    .ld_strb    (dp_strb),
    .ld_data    (HWDATA),
    .rd_addr    (dp_addr),
    .sram_rdata (SRAMRDATA),
    .valid      (wb_valid),
    .addr       (wb_addr),
    .strb       (wb_strb),
    .data       (wb_data),
    .rdata      (fwd_data)
  );

  // Reads own the port in their address phase; the buffer drains otherwise.
  always_comb begin
    SRAMCS0   = 1'b0;
    SRAMWEN   = 8'h00;
    SRAMADDR  = wb_addr;
    SRAMWDATA = wb_data;
    if (rd_acc) begin
      SRAMCS0  = 1'b1;
      SRAMADDR = ap_addr;
    end else if (wb_valid) begin
      SRAMCS0 = 1'b1;
      SRAMWEN = wb_strb;
    end
  end

  assign HRDATA = (state == ST_RD) ? fwd_data : 64'h0;

endmodule

// File: doc/ahbl_sram64_ctrl.md
# ahbl_sram64_ctrl

AHB-Lite slave that bridges the 64-bit system bus to the single-port synchronous 1024x64 SRAM macro, driving its CS/WEN/ADDR/WDATA pins and returning read data. It is the responder on the SRAM slot of the system bus for the core's AHB-Lite master. Reads complete with zero wait states. Writes pass through a one-entry write buffer with byte-level read forwarding. Illegal transfers get a standard two-cycle ERROR response.

## Interface
Parameters:
- AW, 10, SRAM word-address width; SRAMADDR = HADDR[AW+2:3]; upper HADDR bits ignored, so addresses alias.

Ports:
- HCLK  in  1  single clock; SRAM macro runs on the same clock.
- HRESETn  in  1  reset; asynchronous, active-low.
- HSEL  in  1  slave select from the address decoder.
- HADDR  in  32  address.
- HTRANS  in  2  transfer type; only NONSEQ/SEQ (HTRANS[1]=1) start a transfer.
- HWRITE  in  1  1 = write.
- HSIZE  in  3  transfer size, 0..3 legal.
- HWDATA  in  64  write data, valid in the data phase.
- HREADY  in  1  bus-level ready.
- HREADYOUT  out  1  slave ready.
- HRESP  out  1  0 = OKAY, 1 = ERROR.
- HRDATA  out  64  read data.
- SRAMRDATA  in  64  SRAM read data; valid the cycle after a read strobe.
- SRAMADDR  out  AW  SRAM word address.
- SRAMWEN  out  8  per-byte write enables.
- SRAMWDATA  out  64  SRAM write data.
- SRAMCS0  out  1  SRAM enable.

## Operation
- Accept condition: HSEL & HREADY & HTRANS[1]. BUSY and IDLE transfers get OKAY with zero wait states and leave the SRAM untouched.
- Byte strobes from HSIZE and HADDR[2:0]:
  - size 0: 8'h01<<A[2:0]
  - size 1: 8'h03<<{A[2:1],0}
  - size 2: 8'h0F<<{A[2],00}
  - size 3: 8'hFF
- Error condition: an accepted transfer with HSIZE>3, or with an address not aligned to its size. It never touches the SRAM or the write buffer.
- Data-phase FSM, registered at each accept:
  - States: IDLE, RD, WR, ERR1, ERR2.
  - IDLE/RD/WR/ERR2 go to RD, WR, ERR1 or IDLE according to the accepted transfer.
  - ERR1 always goes to ERR2.
- Registered data-phase context: word address, strobes.
- Write buffer (wbuf): valid, addr, strb, data.
  - Loaded at the end of a WR data phase when HREADYOUT=1.
- SRAM arbitration, combinational per cycle:
  - Read-accept cycle: SRAMCS0=1, SRAMWEN=0, SRAMADDR=HADDR word.
  - Otherwise, if wbuf.valid: SRAMCS0=1, SRAMWEN=wbuf.strb, SRAMADDR=wbuf.addr, SRAMWDATA=wbuf.data. wbuf.valid clears at the edge unless it is reloaded in the same cycle.
  - Otherwise SRAMCS0=0 and SRAMWEN=0.
- Read forwarding in the RD state: HRDATA byte k = wbuf.data[k] when wbuf.valid, wbuf.addr equals the read address and wbuf.strb[k] is set; otherwise SRAMRDATA[k].
- HRDATA is 0 outside the RD state.
- Write-buffer conflict:
  - Condition: state WR, wbuf.valid=1, and a read is presented (HSEL & HTRANS[1] & ~HWRITE; HREADY is not used, so there is no combinational loop).
  - Response: HREADYOUT=0 for one cycle. The read is therefore not accepted, wbuf drains, and the WR completes the next cycle.
- Error response:
  - ERR1: HREADYOUT=0, HRESP=1.
  - ERR2: HREADYOUT=1, HRESP=1.
  - A transfer presented during ERR2 is accepted normally.

## Timing
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, SRAMCS0=0, SRAMWEN=0, SRAMADDR=0, SRAMWDATA=0, FSM=IDLE, wbuf.valid=0.
- Read: address phase in cycle N, SRAM strobed in cycle N; HRDATA valid in cycle N+1 with HREADYOUT=1. Zero wait states.
- Write: address phase N, data phase N+1 with zero wait states (except the conflict stall). The SRAM write happens in the first non-read cycle at or after N+2.
- Back-to-back W,W,R: the second W's data phase stalls exactly one cycle.
- A reset asserted mid-transfer returns everything to reset values immediately. A pending wbuf write is lost.

## Structure
- Shared package ahbl_pkg:
  - HTRANS encodings (IDLE, BUSY, NONSEQ, SEQ).
  - HSIZE encodings.
  - HRESP encodings.
  - Data-phase state enum.
  - Function strb_gen(size, addr[2:0]).
- Sub-module ahbl_wbuf: the write buffer, including the valid/load/drain logic and the per-byte forwarding mux.

## Test plan
- Reset, then 64-bit write 0x0123456789ABCDEF to 0x08 followed by IDLE, then read 0x08 -> HRDATA=0x0123456789ABCDEF, zero wait states, SRAMWEN=8'hFF seen exactly once.
- Byte write 0xAA to 0x13 immediately followed by 64-bit read 0x10 -> byte 3 forwarded as 0xAA, other bytes from SRAM, no stall.
- W(0x0,all 1s), W(0x8,0x55..), R(0x0) back-to-back -> the second W data phase shows HREADYOUT=0 for one cycle; the read returns all 1s.
- HSIZE=3 at 0x04, then HSIZE=4 -> each gives ERR1 (HREADYOUT=0, HRESP=1) then ERR2 (1,1); SRAMCS0 stays 0.
- Assert HRESETn low during a WR data phase with wbuf valid -> outputs take reset values asynchronously; a later read of that address returns the old SRAM contents.
- Read of 0x2008 with AW=10 -> SRAMADDR=1 (aliasing).
